sync_fifo_level_controller: RTL and testbench

SYNC_FIFO_LEVEL_CONTROLLER -- requirements
Module: sync_fifo_level_controller

---
 rtl/sync_fifo_level_controller.sv | 126 ++++++++++++
 tb/tb_sync_fifo_level_controller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_level_controller.sv
// Single-clock FIFO with occupancy level, almost-full/empty flags and sticky error flags.
// Standard (registered read) or first-word-fall-through output, selected by pFwft.
module sync_fifo_level_controller #(
    parameter int    pDataWidth = 8,
    parameter int    pDepth     = 256,
    parameter string pFwft      = "no",
    parameter int    pAfullTh   = pDepth - 4,
    parameter int    pAempTh    = 4,
    localparam int   pAddrWidth = $clog2(pDepth)
) (
    input  logic                  iCLK,
    input  logic                  iARST,
    input  logic                  iFlush,
    input  logic [pDataWidth-1:0] iWd,
    input  logic                  iWe,
    output logic                  oFull,
    output logic                  oAfull,
    input  logic                  iRe,
    output logic [pDataWidth-1:0] oRd,
    output logic                  oRvd,
    output logic                  oEmp,
    output logic                  oAemp,
    output logic [pAddrWidth:0]   oLevel,
    output logic                  oOvf,
    output logic                  oUdf
);

    localparam bit                  cFwft  = (pFwft == "yes");
    localparam logic [pAddrWidth:0] cDepth = (pAddrWidth + 1)'(pDepth);
    localparam logic [pAddrWidth:0] cAfull = (pAddrWidth + 1)'(pAfullTh);
    localparam logic [pAddrWidth:0] cAemp  = (pAddrWidth + 1)'(pAempTh);
    localparam logic [pAddrWidth:0] cOne   = (pAddrWidth + 1)'(1);

    logic [pDataWidth-1:0] mem [pDepth];
    logic [pDataWidth-1:0] rd_q;
    logic [pAddrWidth:0]   wptr, rptr, wptr_q, count, count_nxt;
    logic                  rvd, rvd_nxt, full_r, afull_r, aemp_r, ovf, udf;
    logic                  emp, we_acc, consume, fetch, mem_avail;

    // In fwft mode the prefetch compares against a one-cycle-delayed write
    // pointer, so a fresh word reaches the output register two edges after it
    // is written and the array is never read at an address written the same edge.
    always_comb begin
        emp       = cFwft ? ~rvd : (count == '0);
        mem_avail = (wptr_q != rptr);
        we_acc    = iWe & ~full_r & ~iFlush;
        consume   = iRe & ~emp & ~iFlush;
        fetch     = consume;
        rvd_nxt   = consume;
        if (cFwft) begin
            fetch   = mem_avail & (~rvd | consume) & ~iFlush;
            rvd_nxt = fetch | (rvd & ~consume);
        end
        count_nxt = count;
        if (we_acc && !consume) begin
            count_nxt = count + cOne;
        end else if (!we_acc && consume) begin
            count_nxt = count - cOne;
        end
    end

    always_ff @(posedge iCLK) begin
        if (we_acc) begin
            mem[wptr[pAddrWidth-1:0]] <= iWd;
        end
    end

    always_ff @(posedge iCLK or posedge iARST) begin
        if (iARST) begin
            wptr    <= '0;
            rptr    <= '0;
            wptr_q  <= '0;
            count   <= '0;
            rvd     <= 1'b0;
            rd_q    <= '0;
            full_r  <= 1'b0;
            afull_r <= 1'b0;
            aemp_r  <= 1'b1;
            ovf     <= 1'b0;
            udf     <= 1'b0;
        end else if (iFlush) begin
            wptr    <= '0;
            rptr    <= '0;
            wptr_q  <= '0;
            count   <= '0;
            rvd     <= 1'b0;
            rd_q    <= '0;
            full_r  <= 1'b0;
            afull_r <= 1'b0;
            aemp_r  <= 1'b1;
            ovf     <= 1'b0;
            udf     <= 1'b0;
        end else begin
            if (we_acc) begin
                wptr <= wptr + cOne;
            end
            wptr_q <= wptr;
            if (fetch) begin
                rd_q <= mem[rptr[pAddrWidth-1:0]];
                rptr <= rptr + cOne;
            end
            rvd     <= rvd_nxt;
            count   <= count_nxt;
            full_r  <= (count_nxt == cDepth);
            afull_r <= (count_nxt >= cAfull);
            aemp_r  <= (count_nxt <= cAemp);
            if (iWe && full_r) begin
                ovf <= 1'b1;
            end
            if (iRe && emp) begin
                udf <= 1'b1;
            end
        end
    end

    assign oFull  = full_r;
    assign oAfull = afull_r;
    assign oAemp  = aemp_r;
    assign oEmp   = emp;
    assign oRvd   = rvd;
    assign oRd    = rd_q;
    assign oLevel = count;
    assign oOvf   = ovf;
    assign oUdf   = udf;

endmodule

// File: tb/tb_sync_fifo_level_controller.sv
// Directed and scoreboarded checks for sync_fifo_level_controller, one standard
// and one fwft instance at depth 16.
module tb_sync_fifo_level_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       s_flush, s_we, s_re, f_flush, f_we, f_re;
    logic [7:0] s_wd, f_wd, s_rd, f_rd;
    logic       s_full, s_afull, s_rvd, s_emp, s_aemp, s_ovf, s_udf;
    logic       f_full, f_afull, f_rvd, f_emp, f_aemp, f_ovf, f_udf;
    logic [4:0] s_level, f_level;

    sync_fifo_level_controller #(.pDataWidth(8), .pDepth(16), .pFwft("no")) u_std (
        .iCLK(clk), .iARST(rst), .iFlush(s_flush), .iWd(s_wd), .iWe(s_we),
        .oFull(s_full), .oAfull(s_afull), .iRe(s_re), .oRd(s_rd), .oRvd(s_rvd),
        .oEmp(s_emp), .oAemp(s_aemp), .oLevel(s_level), .oOvf(s_ovf), .oUdf(s_udf)
    );

    sync_fifo_level_controller #(.pDataWidth(8), .pDepth(16), .pFwft("yes")) u_fwft (
        .iCLK(clk), .iARST(rst), .iFlush(f_flush), .iWd(f_wd), .iWe(f_we),
        .oFull(f_full), .oAfull(f_afull), .iRe(f_re), .oRd(f_rd), .oRvd(f_rvd),
        .oEmp(f_emp), .oAemp(f_aemp), .oLevel(f_level), .oOvf(f_ovf), .oUdf(f_udf)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rst(input string tag);
        check({tag, "_s_lvl"}, s_level, 0);
        check({tag, "_s_full"}, s_full, 0);
        check({tag, "_s_afull"}, s_afull, 0);
        check({tag, "_s_emp"}, s_emp, 1);
        check({tag, "_s_aemp"}, s_aemp, 1);
        check({tag, "_s_rvd"}, s_rvd, 0);
        check({tag, "_s_rd"}, s_rd, 0);
        check({tag, "_s_ovf"}, s_ovf, 0);
        check({tag, "_s_udf"}, s_udf, 0);
        check({tag, "_f_lvl"}, f_level, 0);
        check({tag, "_f_emp"}, f_emp, 1);
        check({tag, "_f_rvd"}, f_rvd, 0);
        check({tag, "_f_rd"}, f_rd, 0);
        check({tag, "_f_ovf"}, f_ovf, 0);
    endtask

    initial begin
        int written, level_m, cyc;
        bit we, re, wacc, racc;
        logic [7:0] dat, e;

        rst = 1'b1;
        s_flush = 0; s_we = 0; s_re = 0; s_wd = 0;
        f_flush = 0; f_we = 0; f_re = 0; f_wd = 0;
        #2;
        check_rst("reset");
        @(posedge clk);
        #2 rst = 1'b0;

        // std: fill to full, first write on first edge after reset
        for (int i = 0; i < 16; i++) begin
            s_we = 1; s_wd = 8'(i);
            tick();
            check("fill_lvl", s_level, i + 1);
            check("fill_full", s_full, (i == 15));
            check("fill_afull", s_afull, (i + 1 >= 12));
            check("fill_aemp", s_aemp, (i + 1 <= 4));
            check("fill_emp", s_emp, 0);
        end
        s_wd = 8'h55;
        tick();
        s_we = 0;
        check("ovf_lvl", s_level, 16);
        check("ovf_flag", s_ovf, 1);
        check("ovf_rvd", s_rvd, 0);

        // std: drain in order, data one cycle after iRe
        s_re = 1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("drain_rvd", s_rvd, 1);
            check("drain_rd", s_rd, i);
            check("drain_lvl", s_level, 15 - i);
        end
        s_re = 0;
        tick();
        check("drain_end_rvd", s_rvd, 0);
        check("drain_hold_rd", s_rd, 8'h0F);
        check("drain_emp", s_emp, 1);
        check("drain_udf", s_udf, 0);

        // std: full with simultaneous write and read
        s_flush = 1;
        tick();
        s_flush = 0;
        check("flush_ovf", s_ovf, 0);
        check("flush_lvl", s_level, 0);
        for (int i = 0; i < 16; i++) begin
            s_we = 1; s_wd = 8'(8'h20 + i);
            tick();
        end
        check("refill_full", s_full, 1);
        s_wd = 8'h99; s_re = 1;
        tick();
        s_we = 0;
        check("fullrw_lvl", s_level, 15);
        check("fullrw_ovf", s_ovf, 1);
        check("fullrw_rvd", s_rvd, 1);
        check("fullrw_rd", s_rd, 8'h20);
        check("fullrw_full", s_full, 0);
        for (int i = 0; i < 15; i++) begin
            tick();
            check("fullrw_drain_rd", s_rd, 8'h21 + i);
        end
        s_re = 0;
        tick();
        check("fullrw_emp", s_emp, 1);

        // std: empty with simultaneous write and read
        s_we = 1; s_re = 1; s_wd = 8'h77;
        tick();
        s_re = 0;
        check("emprw_lvl", s_level, 1);
        check("emprw_udf", s_udf, 1);
        check("emprw_rvd", s_rvd, 0);
        for (int i = 0; i < 8; i++) begin
            s_wd = 8'(8'h78 + i);
            tick();
        end
        check("lvl9", s_level, 9);

        // flush overrides a concurrent write
        s_flush = 1; s_wd = 8'hCC;
        tick();
        s_flush = 0; s_we = 0;
        check("flushw_lvl", s_level, 0);
        check("flushw_emp", s_emp, 1);
        check("flushw_ovf", s_ovf, 0);
        check("flushw_udf", s_udf, 0);
        check("flushw_aemp", s_aemp, 1);
        check("flushw_afull", s_afull, 0);
        check("flushw_rd", s_rd, 0);

        // std: random stream against scoreboard
        written = 0; level_m = 0; cyc = 0;
        while ((written < 100 || level_m > 0) && cyc < 3000) begin
            we = (written < 100) && ($urandom_range(0, 99) < 55);
            re = ($urandom_range(0, 99) < 50);
            wacc = we && (level_m != 16);
            racc = re && (level_m != 0);
            dat = 8'(written * 7 + 3);
            s_we = we; s_re = re; s_wd = dat;
            tick();
            if (racc) begin
                e = exp_q.pop_front();
                check("strm_rvd", s_rvd, 1);
                check("strm_rd", s_rd, e);
            end else begin
                check("strm_rvd", s_rvd, 0);
            end
            if (wacc) begin
                exp_q.push_back(dat);
                written++;
            end
            level_m = level_m + int'(wacc) - int'(racc);
            check("strm_lvl", s_level, level_m);
            check("strm_emp", s_emp, (level_m == 0));
            cyc++;
        end
        s_we = 0; s_re = 0;
        check("strm_done", (written == 100) && (level_m == 0), 1);

        // fwft: single word latency and consume
        f_we = 1; f_wd = 8'hA5;
        tick();
        f_we = 0;
        check("fw_w0_rvd", f_rvd, 0);
        check("fw_w0_lvl", f_level, 1);
        tick();
        check("fw_w1_rvd", f_rvd, 0);
        tick();
        check("fw_w2_rvd", f_rvd, 1);
        check("fw_w2_rd", f_rd, 8'hA5);
        check("fw_w2_emp", f_emp, 0);
        f_re = 1;
        tick();
        f_re = 0;
        check("fw_c_rvd", f_rvd, 0);
        check("fw_c_emp", f_emp, 1);
        check("fw_c_lvl", f_level, 0);

        // fwft: full capacity, overflow, back-to-back drain, underflow
        for (int i = 0; i < 16; i++) begin
            f_we = 1; f_wd = 8'(8'h40 + i);
            tick();
        end
        check("fw_full", f_full, 1);
        check("fw_full_lvl", f_level, 16);
        f_wd = 8'hEE;
        tick();
        f_we = 0;
        check("fw_ovf", f_ovf, 1);
        check("fw_ovf_lvl", f_level, 16);
        tick();
        f_re = 1;
        for (int i = 0; i < 16; i++) begin
            check("fw_b2b_rvd", f_rvd, 1);
            check("fw_b2b_rd", f_rd, 8'h40 + i);
            tick();
            check("fw_b2b_lvl", f_level, 15 - i);
        end
        check("fw_end_rvd", f_rvd, 0);
        check("fw_end_udf0", f_udf, 0);
        tick();
        f_re = 0;
        check("fw_udf", f_udf, 1);
        check("fw_end_emp", f_emp, 1);

        // asynchronous reset mid-burst, then immediate write
        s_we = 1;
        for (int i = 0; i < 3; i++) begin
            s_wd = 8'(8'h10 + i);
            tick();
        end
        check("burst_lvl", s_level, 3);
        rst = 1'b1;
        #2;
        check_rst("midrst");
        s_wd = 8'h3C;
        #1 rst = 1'b0;
        tick();
        s_we = 0;
        check("postrst_lvl", s_level, 1);
        s_re = 1;
        tick();
        s_re = 0;
        check("postrst_rvd", s_rvd, 1);
        check("postrst_rd", s_rd, 8'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
